// File: rtl/console_text_buffer.sv
// console_text_buffer
// Character-cell text buffer feeding the console glyph renderer. Each screen
// cell holds {attribute, codepoint}. Pixel coordinates are turned into cell
// lookups through a two-stage read pipeline. A valid/ready port writes single
// cells, and a small sequencer runs clear-screen and scroll-up fills.
// A scroll is a rotation of the top_row pointer followed by blanking the row
// that has become the new bottom row.
//
// FSM states:
//   state     | meaning
//   IDLE      | accepting cell writes, watching clear_req / scroll_req
//   CLEAR_ALL | blanking every RAM entry, top_row returns to 0 at the end
//   CLEAR_ROW | blanking the physical row freed by a scroll
module console_text_buffer #(
  parameter int          COLUMNS         = 80,
  parameter int          ROWS            = 30,
  parameter int          CHAR_WIDTH      = 8,
  parameter int          CHAR_HEIGHT     = 16,
  parameter int          BIT_WIDTH       = 10,
  parameter logic [7:0]  BLANK_CODEPOINT = 8'h20,
  parameter logic [7:0]  BLANK_ATTRIBUTE = 8'h07
) (
  input  logic                 clk_pixel,
  input  logic                 reset_n,
  input  logic [BIT_WIDTH-1:0] cx,
  input  logic [BIT_WIDTH-1:0] cy,
  output logic [7:0]           codepoint,
  output logic [7:0]           attribute,
  output logic [BIT_WIDTH-1:0] cx_out,
  output logic [BIT_WIDTH-1:0] cy_out,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [6:0]           wr_col,
  input  logic [4:0]           wr_row,
  input  logic [15:0]          wr_data,
  input  logic                 clear_req,
  input  logic                 scroll_req,
  output logic                 busy
);

  localparam int TOTAL = COLUMNS * ROWS;
  localparam int AW    = $clog2(TOTAL);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLUMNS);
  localparam int XSH   = $clog2(CHAR_WIDTH);
  localparam int YSH   = $clog2(CHAR_HEIGHT);

  typedef enum logic [1:0] {IDLE, CLEAR_ALL, CLEAR_ROW} state_t;

  logic [15:0]          r_mem [TOTAL];
  state_t               r_state;
  logic [RW-1:0]        r_top_row;
  logic [AW-1:0]        r_fill_addr;
  logic [AW-1:0]        r_fill_left;

  logic [AW-1:0]        r_rd_addr;
  logic                 r_rd_valid;
  logic [BIT_WIDTH-1:0] r_cx1;
  logic [BIT_WIDTH-1:0] r_cy1;

  logic [BIT_WIDTH-1:0] w_cx_cell;
  logic [BIT_WIDTH-1:0] w_cy_cell;
  logic [BIT_WIDTH:0]   w_rd_row_sum;
  logic [RW-1:0]        w_rd_row;
  logic [CW-1:0]        w_rd_col;
  logic                 w_rd_in_range;
  logic [AW-1:0]        w_rd_addr;
  logic [15:0]          w_rd_word;

  logic [5:0]           w_wr_row_sum;
  logic [4:0]           w_wr_row;
  logic [AW-1:0]        w_wr_addr;
  logic                 w_wr_in_range;

  logic                 w_mem_we;
  logic [AW-1:0]        w_mem_addr;
  logic [15:0]          w_mem_wdata;

  // Display-side cell lookup: pixel -> cell -> physical row via top_row.
  assign w_cx_cell     = cx >> XSH;
  assign w_cy_cell     = cy >> YSH;
  assign w_rd_in_range = (w_cx_cell < BIT_WIDTH'(COLUMNS)) && (w_cy_cell < BIT_WIDTH'(ROWS));
  assign w_rd_row_sum  = (BIT_WIDTH+1)'(w_cy_cell) + (BIT_WIDTH+1)'(r_top_row);
  assign w_rd_row      = RW'((w_rd_row_sum >= (BIT_WIDTH+1)'(ROWS)) ?
                             (w_rd_row_sum - (BIT_WIDTH+1)'(ROWS)) : w_rd_row_sum);
  assign w_rd_col      = CW'(w_cx_cell);
  assign w_rd_addr     = AW'(w_rd_row) * AW'(COLUMNS) + AW'(w_rd_col);
  assign w_rd_word     = r_mem[r_rd_addr];

  // Host-side cell write uses the same logical-to-physical row rotation.
  assign w_wr_in_range = (wr_col < 7'(COLUMNS)) && (wr_row < 5'(ROWS));
  assign w_wr_row_sum  = {1'b0, wr_row} + 6'(r_top_row);
  assign w_wr_row      = 5'((w_wr_row_sum >= 6'(ROWS)) ? (w_wr_row_sum - 6'(ROWS)) : w_wr_row_sum);
  assign w_wr_addr     = AW'(w_wr_row) * AW'(COLUMNS) + AW'(wr_col);

  // Single RAM write port shared between host writes (IDLE) and blank fills.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = w_wr_addr;
    w_mem_wdata = wr_data;
    if (r_state == IDLE) begin
      w_mem_we = wr_valid && wr_ready && w_wr_in_range;
    end else begin
      w_mem_we    = reset_n;
      w_mem_addr  = r_fill_addr;
      w_mem_wdata = {BLANK_ATTRIBUTE, BLANK_CODEPOINT};
    end
  end

  // Cell RAM write; the display port reads the pre-write contents on a collision.
  always_ff @(posedge clk_pixel) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  // Two-stage read pipeline: address/coords in S1, RAM data and coords out in S2.
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      r_rd_addr  <= '0;
      r_rd_valid <= 1'b0;
      r_cx1      <= '0;
      r_cy1      <= '0;
      codepoint  <= '0;
      attribute  <= '0;
      cx_out     <= '0;
      cy_out     <= '0;
    end else begin
      r_rd_addr  <= w_rd_addr;
      r_rd_valid <= w_rd_in_range;
      r_cx1      <= cx;
      r_cy1      <= cy;
      codepoint  <= r_rd_valid ? w_rd_word[7:0]  : 8'h00;
      attribute  <= r_rd_valid ? w_rd_word[15:8] : 8'h00;
      cx_out     <= r_cx1;
      cy_out     <= r_cy1;
    end
  end

  // Clear/scroll sequencer; fill length is a down-counter to terminal count zero.
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      r_state     <= CLEAR_ALL;
      r_top_row   <= '0;
      r_fill_addr <= '0;
      r_fill_left <= AW'(TOTAL - 1);
      wr_ready    <= 1'b0;
      busy        <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (clear_req) begin
            r_state     <= CLEAR_ALL;
            r_fill_addr <= '0;
            r_fill_left <= AW'(TOTAL - 1);
            wr_ready    <= 1'b0;
            busy        <= 1'b1;
          end else if (scroll_req) begin
            r_state     <= CLEAR_ROW;
            r_top_row   <= (r_top_row == RW'(ROWS - 1)) ? '0 : r_top_row + 1'b1;
            r_fill_addr <= AW'(r_top_row) * AW'(COLUMNS);
            r_fill_left <= AW'(COLUMNS - 1);
            wr_ready    <= 1'b0;
            busy        <= 1'b1;
          end
        end
        CLEAR_ALL, CLEAR_ROW: begin
          r_fill_addr <= r_fill_addr + 1'b1;
          r_fill_left <= r_fill_left - 1'b1;
          if (r_fill_left == '0) begin
            if (r_state == CLEAR_ALL) r_top_row <= '0;
            r_state  <= IDLE;
            wr_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: begin
          r_state     <= CLEAR_ALL;
          r_fill_addr <= '0;
          r_fill_left <= AW'(TOTAL - 1);
          wr_ready    <= 1'b0;
          busy        <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_console_text_buffer.sv
// Bench for console_text_buffer: the reference model is the logical screen
// (rows x columns as seen by the host); scrolling shifts that picture up.
module tb_console_text_buffer;

  logic        clk_pixel = 1'b0;
  logic        reset_n;
  logic [9:0]  cx, cy;
  logic [7:0]  codepoint, attribute;
  logic [9:0]  cx_out, cy_out;
  logic        wr_valid, wr_ready;
  logic [6:0]  wr_col;
  logic [4:0]  wr_row;
  logic [15:0] wr_data;
  logic        clear_req, scroll_req, busy;

  always #5 clk_pixel = ~clk_pixel;

  console_text_buffer dut (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .cx(cx), .cy(cy),
    .codepoint(codepoint), .attribute(attribute), .cx_out(cx_out), .cy_out(cy_out),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_col(wr_col), .wr_row(wr_row),
    .wr_data(wr_data), .clear_req(clear_req), .scroll_req(scroll_req), .busy(busy)
  );

  localparam logic [15:0] BLANK = 16'h0720;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] screen [30][80];
  logic [15:0] pend_word [2];
  logic [19:0] pend_xy [2];
  int          pend_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_cell(input int x, input int y);
    int col, row;
    col = x / 8;
    row = y / 16;
    if (col < 80 && row < 30) return screen[row][col];
    return 16'h0000;
  endfunction

  task automatic model_blank_all();
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++) screen[r][c] = BLANK;
  endtask

  task automatic model_scroll();
    for (int r = 0; r < 29; r++)
      for (int c = 0; c < 80; c++) screen[r][c] = screen[r+1][c];
    for (int c = 0; c < 80; c++) screen[29][c] = BLANK;
  endtask

  // One pixel per cycle; output two cycles later is compared with the model.
  task automatic step(input int x, input int y);
    @(negedge clk_pixel);
    if (pend_n >= 2) begin
      chk("rd_cell", {16'h0, attribute, codepoint}, {16'h0, pend_word[0]});
      chk("rd_xy", {12'h0, cx_out, cy_out}, {12'h0, pend_xy[0]});
    end
    pend_word[0] = pend_word[1];
    pend_xy[0]   = pend_xy[1];
    cx = 10'(x);
    cy = 10'(y);
    pend_word[1] = ref_cell(x, y);
    pend_xy[1]   = {10'(x), 10'(y)};
    if (pend_n < 2) pend_n++;
  endtask

  task automatic scan_flush();
    step(0, 0);
    step(0, 0);
    pend_n = 0;
  endtask

  task automatic scan_row(input int r);
    pend_n = 0;
    for (int c = 0; c < 80; c++)
      step(c * 8 + int'($urandom_range(0, 7)), r * 16 + int'($urandom_range(0, 15)));
    scan_flush();
  endtask

  task automatic scan_all();
    for (int r = 0; r < 30; r++) scan_row(r);
  endtask

  task automatic scan_rand(input int n);
    pend_n = 0;
    for (int i = 0; i < n; i++)
      step(int'($urandom_range(0, 700)), int'($urandom_range(0, 540)));
    scan_flush();
  endtask

  task automatic do_write(input int col, input int row, input logic [15:0] data, output int waited);
    int n;
    @(negedge clk_pixel);
    wr_valid = 1'b1;
    wr_col   = 7'(col);
    wr_row   = 5'(row);
    wr_data  = data;
    n = 0;
    while (!wr_ready && n < 5000) begin
      @(negedge clk_pixel);
      n++;
    end
    chk("wr_timeout", {31'h0, n < 5000}, 32'h1);
    @(negedge clk_pixel);
    wr_valid = 1'b0;
    if (col < 80 && row < 30) screen[row][col] = data;
    waited = n;
  endtask

  task automatic rand_writes(input int n);
    int w;
    for (int i = 0; i < n; i++)
      do_write(int'($urandom_range(0, 79)), int'($urandom_range(0, 29)), 16'($urandom), w);
  endtask

  task automatic pulse(input logic clr, input logic scr);
    @(negedge clk_pixel);
    clear_req  = clr;
    scroll_req = scr;
    @(negedge clk_pixel);
    clear_req  = 1'b0;
    scroll_req = 1'b0;
  endtask

  task automatic measure_busy(output int cnt);
    cnt = 0;
    if (busy) chk("rdy_while_busy", {31'h0, wr_ready}, 32'h0);
    while (busy && cnt < 5000) begin
      @(negedge clk_pixel);
      cnt++;
    end
  endtask

  task automatic do_reset(input int cycles);
    int cnt;
    @(negedge clk_pixel);
    reset_n = 1'b0;
    cx = 10'd123;
    cy = 10'd77;
    repeat (cycles) @(negedge clk_pixel);
    chk("rst_cell", {16'h0, attribute, codepoint}, 32'h0);
    chk("rst_xy", {12'h0, cx_out, cy_out}, 32'h0);
    chk("rst_busy", {30'h0, busy, wr_ready}, 32'h2);
    reset_n = 1'b1;
    measure_busy(cnt);
    chk("rst_busy_len", cnt, 2400);
    chk("rst_ready", {31'h0, wr_ready}, 32'h1);
    model_blank_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, cnt;
    logic [15:0] d;
    reset_n = 1'b0; cx = '0; cy = '0;
    wr_valid = 1'b0; wr_col = '0; wr_row = '0; wr_data = '0;
    clear_req = 1'b0; scroll_req = 1'b0;
    pend_n = 0;
    model_blank_all();

    // reset and blank screen
    do_reset(4);
    scan_all();

    // single write and block read of its cell
    do_write(3, 2, {8'h1E, 8'h41}, w);
    pend_n = 0;
    for (int y = 32; y < 48; y++)
      for (int x = 24; x < 32; x++) step(x, y);
    scan_flush();

    // random writes, random reads including out-of-range pixels
    rand_writes(40);
    scan_rand(300);
    pend_n = 0;
    step(640, 0); step(0, 480); step(1023, 1023); step(639, 479);
    scan_flush();

    // out-of-range writes handshake immediately and change nothing
    do_write(80, 5, 16'hBEEF, w);
    chk("oor_col_wait", w, 0);
    do_write(10, 31, 16'hCAFE, w);
    chk("oor_row_wait", w, 0);
    do_write(127, 29, 16'hF00D, w);
    scan_row(5); scan_row(6); scan_row(0); scan_row(29);

    // scroll: row r carries codepoint 0x30+r
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 16; c++)
        do_write(c, r, {8'($urandom_range(1, 255)), 8'(8'h30 + r)}, w);
    pulse(1'b0, 1'b1);
    measure_busy(cnt);
    chk("scroll_busy_len", cnt, 80);
    model_scroll();
    chk("scroll_row0", {24'h0, screen[0][0][7:0]}, 32'h31);
    scan_row(0); scan_row(29); scan_row(15);

    // repeated scrolls across the top_row wrap
    for (int k = 0; k < 32; k++) begin
      rand_writes(4);
      do_write(int'($urandom_range(0, 79)), 29, 16'($urandom), w);
      pulse(1'b0, 1'b1);
      measure_busy(cnt);
      chk("wrap_busy_len", cnt, 80);
      model_scroll();
      scan_row(29);
      scan_row(28);
      scan_row(int'($urandom_range(0, 27)));
    end

    // simultaneous clear and scroll: clear wins
    rand_writes(20);
    pulse(1'b1, 1'b1);
    measure_busy(cnt);
    chk("contend_busy_len", cnt, 2400);
    model_blank_all();
    scan_rand(200);
    rand_writes(10);
    pulse(1'b0, 1'b1);
    measure_busy(cnt);
    model_scroll();
    scan_rand(200);

    // write held through a clear is accepted only afterwards
    rand_writes(10);
    pulse(1'b1, 1'b0);
    model_blank_all();
    d = 16'h5A33;
    do_write(7, 9, d, w);
    chk("wr_wait_busy", w, 2399);
    scan_row(9);

    // reset in the middle of a scroll restarts the full clear
    rand_writes(10);
    pulse(1'b0, 1'b1);
    repeat (10) @(negedge clk_pixel);
    do_reset(2);
    scan_rand(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
